// File: rtl/alu_seq_pkg.sv
// Shared widths, command payload and FSM state encoding for the ALU sequencer.
package alu_seq_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned OPND_W   = 3;
  localparam int unsigned RESULT_W = 6;
  localparam int unsigned CMD_W    = OPCODE_W + 2 * OPND_W;

  localparam logic [OPCODE_W-1:0] OPCODE_MAX = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [OPND_W-1:0]   a;
    logic [OPND_W-1:0]   b;
  } cmd_t;

  // Opcodes above OPCODE_MAX are reserved and must never reach the ALU.
  function automatic logic op_illegal(input logic [OPCODE_W-1:0] op);
    return op > OPCODE_MAX;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command push port and tagged result port of the ALU sequencer.
interface alu_sequencer_if;
  import alu_seq_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [OPCODE_W-1:0] in_opcode;
  logic [OPND_W-1:0]   in_a;
  logic [OPND_W-1:0]   in_b;

  logic                out_valid;
  logic                out_ready;
  logic [RESULT_W-1:0] out_result;
  logic [OPCODE_W-1:0] out_opcode;

  modport slave (
    input  in_valid, in_opcode, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_opcode
  );

  modport master (
    output in_valid, in_opcode, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_opcode
  );

endinterface

// File: rtl/alu_seq_fifo.sv
// Command FIFO: power-of-two depth, wrap-bit pointers, no push-to-pop bypass.
module alu_seq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Extra MSB distinguishes full from empty when the address bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_sequencer.sv
// Issues queued ALU commands one at a time and returns opcode-tagged results in order.
// Optional reserved-opcode filtering is enabled by defining ALU_SEQUENCER_OPCHK_EN.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  alu_sequencer_if.slave      bus,
  output logic [OPCODE_W-1:0] alu_opcode,
  output logic [OPND_W-1:0]   alu_a,
  output logic [OPND_W-1:0]   alu_b,
  input  logic [RESULT_W-1:0] alu_result,
  output logic                busy,
  output logic                err_illegal
);

  localparam int unsigned CNT_W = $clog2(ALU_LAT + 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  cmd_t                issue_q, issue_d;
  logic                out_valid_q, out_valid_d;
  logic [RESULT_W-1:0] out_result_q, out_result_d;
  logic [OPCODE_W-1:0] out_opcode_q, out_opcode_d;

  cmd_t                wcmd;
  logic [CMD_W-1:0]    fifo_rdata;
  cmd_t                head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic                try_issue;

  assign wcmd = '{opcode: bus.in_opcode, a: bus.in_a, b: bus.in_b};
  assign head = fifo_rdata;

  alu_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.in_valid),
    .pop   (fifo_pop),
    .wdata (wcmd),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef ALU_SEQUENCER_OPCHK_EN
  logic err_q, err_d;
`endif

  // Next-state, issue and result-capture logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    issue_d      = issue_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_opcode_d = out_opcode_q;
    fifo_pop     = 1'b0;
    try_issue    = 1'b0;
`ifdef ALU_SEQUENCER_OPCHK_EN
    err_d        = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (!fifo_empty) try_issue = 1'b1;
      end
      EXEC: begin
        // Counter reaching zero means ALU_LAT cycles have elapsed since alu_* changed.
        if (cnt_q == '0) begin
          out_valid_d  = 1'b1;
          out_result_d = alu_result;
          out_opcode_d = issue_q.opcode;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
          if (!fifo_empty) try_issue = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (try_issue) begin
      fifo_pop = 1'b1;
`ifdef ALU_SEQUENCER_OPCHK_EN
      // Reserved opcodes are consumed without touching the ALU operands.
      if (op_illegal(head.opcode)) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        issue_d = head;
        cnt_d   = CNT_W'(ALU_LAT);
        state_d = EXEC;
      end
`else
      issue_d = head;
      cnt_d   = CNT_W'(ALU_LAT);
      state_d = EXEC;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      issue_q      <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_opcode_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      issue_q      <= issue_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_opcode_q <= out_opcode_d;
    end
  end

`ifdef ALU_SEQUENCER_OPCHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign err_illegal = err_q;
`else
  assign err_illegal = 1'b0;
`endif

  assign alu_opcode     = issue_q.opcode;
  assign alu_a          = issue_q.a;
  assign alu_b          = issue_q.b;
  assign bus.in_ready   = !fifo_full;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_opcode = out_opcode_q;
  assign busy           = (state_q != IDLE) || !fifo_empty;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, min 2).
REQ-002 SHALL have parameter ALU_LAT, default 1, cycles from alu_* change to alu_result valid (min 1).
REQ-003 SHALL have clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have in_valid input 1, in_ready output 1, in_opcode input 4, in_a input 3, in_b input 3: command push port.
REQ-006 SHALL have alu_opcode output 4, alu_a output 3, alu_b output 3: operands driven to the ALU.
REQ-007 SHALL have alu_result input 6: ALU output.
REQ-008 SHALL have out_valid output 1, out_ready input 1, out_result output 6, out_opcode output 4: result port, opcode as tag.
REQ-009 SHALL have busy output 1 (FSM not IDLE or FIFO non-empty) and err_illegal output 1.

Function
REQ-010 Push SHALL occur on in_valid && in_ready; in_ready = !full, no same-cycle pop bypass.
REQ-011 Pushed entry SHALL be poppable no earlier than the next cycle; FIFO pointers SHALL wrap modulo DEPTH.
REQ-012 FSM states SHALL be IDLE, EXEC, RESP.
REQ-013 IDLE->EXEC when FIFO non-empty: pop head into issue register driving alu_*, load latency counter with ALU_LAT.
REQ-014 EXEC SHALL hold alu_* stable and decrement counter; when counter reaches 0, sample alu_result into out_result, issue opcode into out_opcode, set out_valid, go RESP.
REQ-015 RESP SHALL hold out_result/out_opcode/out_valid stable until out_valid && out_ready; then go EXEC (popping next head same edge) if FIFO non-empty, else IDLE.
REQ-016 alu_* SHALL retain last issued values in IDLE/RESP.
REQ-017 Push while full SHALL be ignored (in_ready=0); push and pop same cycle SHALL keep count unchanged.
REQ-018 Commands SHALL complete strictly in push order; no result SHALL be dropped under out_ready=0 backpressure.

Reset
REQ-019 On rst assertion, immediately: FIFO empty, FSM IDLE, counter 0, in_ready=1 after release, all other outputs 0.
REQ-020 rst mid-EXEC or mid-RESP SHALL discard the in-flight command and all queued commands; no out_valid after release until a new push completes.

Configuration
REQ-021 Macro ALU_SEQUENCER_OPCHK_EN defined: popped opcode > 4'b1100 SHALL not be issued; err_illegal SHALL pulse 1 cycle, FSM stays/returns IDLE, alu_* unchanged.
REQ-022 Macro undefined: all opcodes issued; err_illegal SHALL be tied 0.

Structure
REQ-023 Package alu_seq_pkg SHALL hold OPCODE_W=4, OPND_W=3, RESULT_W=6, OPCODE_MAX=4'b1100 and the state enum.
REQ-024 FIFO SHALL be a sub-module alu_seq_fifo (DEPTH, WIDTH=10), flags full/empty.

Verification (bench ALU stub: alu_result <= {alu_a,alu_b} registered, ALU_LAT=1)
REQ-025 Push {0000,101,110}, out_ready=1 -> out_valid with out_result=6'b101110, out_opcode=0000; busy low afterwards.
REQ-026 Push 0000, 0011, 1100 back-to-back, a=101,b=110 -> three results in order, tags 0000/0011/1100, each out_result=6'b101110.
REQ-027 out_ready=0, push 5 commands (DEPTH=4) -> in_ready low after 4 queued + 1 in flight; release out_ready -> all accepted results delivered in order, none lost.
REQ-028 Assert rst during RESP with 2 queued -> out_valid=0 immediately, busy=0, no stale result after release.
REQ-029 ALU_SEQUENCER_OPCHK_EN defined, push 1101 then 0011 -> err_illegal pulses once, only 0011 result appears; undefined -> both results appear, err_illegal=0.
